imem_loader: RTL and testbench

Wishbone-slave instruction-memory loader that lets the management SoC write and read back a parametrised bank of SRAM macros, replacing bit-banged logic-analyzer writes. Sits in `user_project_wrapper` between the Wishbone MI-A port and port 0 (RW) of each instruction SRAM. Holds the core in reset while a program is loaded.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_regs.sv | 61 ++++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and register map for the Wishbone instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD1,
    ST_RD2,
    ST_ACK
  } state_t;

  // adr[REGION_BIT] splits register space (0) from the SRAM window (1).
  localparam int REGION_BIT = 23;
  localparam int OFF_W      = REGION_BIT;

  localparam logic [OFF_W-1:0] CTRL_OFF   = 23'h0;
  localparam logic [OFF_W-1:0] STATUS_OFF = 23'h4;

  localparam int CTRL_HOLD_BIT  = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int STATUS_OOB_BIT = 0;

endpackage

// File: rtl/imem_loader_regs.sv
// CTRL/STATUS storage: core hold bit, saturating write counter, sticky out-of-range flag.
module imem_loader_regs
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_we,
  input  logic [OFF_W-1:0]  reg_off,
  input  logic              byte0_en,
  input  logic [1:0]        ctrl_bits,
  input  logic              cnt_inc,
  input  logic              oob_set,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              core_hold,
  output logic [15:0]       word_count
);

  logic        ctrl_wr;
  logic        clr;
  logic        oob;
  logic [15:0] count_q;
  logic [31:0] rdata32;

  assign ctrl_wr = reg_we & byte0_en & (reg_off == CTRL_OFF);
  assign clr     = ctrl_wr & ctrl_bits[CTRL_CLR_BIT];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_hold <= 1'b1;
      oob       <= 1'b0;
      count_q   <= '0;
    end else begin
      if (clr) begin
        count_q <= '0;
        oob     <= 1'b0;
      end else begin
        if (cnt_inc && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        if (oob_set) oob <= 1'b1;
      end
      if (ctrl_wr) core_hold <= ctrl_bits[CTRL_HOLD_BIT];
    end
  end

  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    rdata32 = '0;
    if (reg_off == CTRL_OFF) begin
      rdata32[CTRL_HOLD_BIT] = core_hold;
    end else if (reg_off == STATUS_OFF) begin
      rdata32[STATUS_OOB_BIT] = oob;
      rdata32[31:16]          = count_q;
    end
  end

  assign reg_rdata  = DATA_W'(rdata32);
  assign word_count = count_q;

endmodule

// File: rtl/imem_loader.sv
// Wishbone slave that loads/reads back a bank of instruction SRAMs and holds the core in reset.
// Optional memory readback path enabled by defining IMEM_LDR_READBACK_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W  = 9,
  parameter int         DATA_W  = 32,
  parameter int         N_BANKS = 2,
  parameter logic [7:0] BASE_HI = 8'h30
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [DATA_W/8-1:0]       wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [DATA_W-1:0]         wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [DATA_W-1:0]         wbs_dat_o,
  output logic [N_BANKS-1:0]        mem_csb0,
  output logic                      mem_web0,
  output logic [DATA_W/8-1:0]       mem_wmask0,
  output logic [ADDR_W-1:0]         mem_addr0,
  output logic [DATA_W-1:0]         mem_din0,
  input  logic [N_BANKS*DATA_W-1:0] mem_dout0,
  output logic                      core_rst_n,
  output logic [15:0]               word_count
);

  state_t              state;
  logic                hit;
  logic                idle_hit;
  logic                is_mem;
  logic                bank_ok;
  logic [1:0]          bank;
  logic [ADDR_W-1:0]   word;
  logic [N_BANKS-1:0]  bank_sel_n;
  logic [DATA_W-1:0]   reg_rdata;
  logic                core_hold;

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
  assign idle_hit   = hit & (state == ST_IDLE);
  assign is_mem     = wbs_adr_i[REGION_BIT];
  assign word       = wbs_adr_i[2 +: ADDR_W];
  assign bank       = wbs_adr_i[2+ADDR_W +: 2];
  assign bank_ok    = int'(bank) < N_BANKS;
  assign bank_sel_n = ~(N_BANKS'(1) << bank);

  imem_loader_regs #(.DATA_W(DATA_W)) u_regs (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n),
    .reg_we     (idle_hit & ~is_mem & wbs_we_i),
    .reg_off    (wbs_adr_i[OFF_W-1:0]),
    .byte0_en   (wbs_sel_i[0]),
    .ctrl_bits  (wbs_dat_i[1:0]),
    .cnt_inc    (idle_hit & is_mem & bank_ok & wbs_we_i),
    .oob_set    (idle_hit & is_mem & ~bank_ok),
    .reg_rdata  (reg_rdata),
    .core_hold  (core_hold),
    .word_count (word_count)
  );

`ifdef IMEM_LDR_READBACK_EN
  logic [1:0]        bank_q;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_q == 2'(b)) rd_word = mem_dout0[b*DATA_W +: DATA_W];
    end
  end
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= ST_IDLE;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      mem_csb0   <= '1;
      mem_web0   <= 1'b1;
      mem_wmask0 <= '0;
      mem_addr0  <= '0;
      mem_din0   <= '0;
      core_rst_n <= 1'b0;
`ifdef IMEM_LDR_READBACK_EN
      bank_q     <= '0;
`endif
    end else begin
      // SRAM strobes and ack are single-cycle pulses; states below override these defaults.
      wbs_ack_o  <= 1'b0;
      mem_csb0   <= '1;
      mem_web0   <= 1'b1;
      core_rst_n <= ~core_hold;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            if (!is_mem || !bank_ok) begin
              if (!wbs_we_i) wbs_dat_o <= is_mem ? '0 : reg_rdata;
              wbs_ack_o <= 1'b1;
              state     <= ST_ACK;
            end else if (wbs_we_i) begin
              mem_csb0   <= bank_sel_n;
              mem_web0   <= 1'b0;
              mem_wmask0 <= wbs_sel_i;
              mem_addr0  <= word;
              mem_din0   <= wbs_dat_i;
              state      <= ST_WR;
            end else begin
`ifdef IMEM_LDR_READBACK_EN
              mem_csb0  <= bank_sel_n;
              mem_addr0 <= word;
              bank_q    <= bank;
              state     <= ST_RD1;
`else
              wbs_dat_o <= '0;
              wbs_ack_o <= 1'b1;
              state     <= ST_ACK;
`endif
            end
          end
        end
        ST_WR: begin
          wbs_ack_o <= 1'b1;
          state     <= ST_ACK;
        end
`ifdef IMEM_LDR_READBACK_EN
        ST_RD1: state <= ST_RD2;
        ST_RD2: begin
          wbs_dat_o <= rd_word;
          wbs_ack_o <= 1'b1;
          state     <= ST_ACK;
        end
`endif
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expectations follow IMEM_LDR_READBACK_EN when defined.
module tb_imem_loader;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int N_BANKS = 2;
`ifdef IMEM_LDR_READBACK_EN
  localparam int  RD_LAT = 3;
  localparam bit  RB     = 1'b1;
`else
  localparam int  RD_LAT = 1;
  localparam bit  RB     = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]                sel = '0;
  logic [31:0]               adr = '0;
  logic [31:0]               dat_i = '0;
  logic                      ack;
  logic [31:0]               dat_o;
  logic [1:0]                csb;
  logic                      web;
  logic [3:0]                wmask;
  logic [ADDR_W-1:0]         maddr;
  logic [31:0]               mdin;
  logic [N_BANKS*DATA_W-1:0] mdout;
  logic                      core_rst_n;
  logic [15:0]               word_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_BANKS(N_BANKS), .BASE_HI(8'h30)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n   (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .mem_csb0   (csb),
    .mem_web0   (web),
    .mem_wmask0 (wmask),
    .mem_addr0  (maddr),
    .mem_din0   (mdin),
    .mem_dout0  (mdout),
    .core_rst_n (core_rst_n),
    .word_count (word_count)
  );

  // Behavioural SRAM pair: registered read data, byte-masked writes.
  logic [31:0] sram [N_BANKS][512] = '{default: '0};
  logic [31:0] dout [N_BANKS];
  always @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (!csb[b]) begin
        if (!web) begin
          for (int k = 0; k < 4; k++)
            if (wmask[k]) sram[b][maddr][8*k +: 8] <= mdin[8*k +: 8];
        end else begin
          dout[b] <= sram[b][maddr];
        end
      end
    end
  end
  assign mdout = {dout[1], dout[0]};

  // Strobe monitor: counts cycles with any chip select active and records the last one.
  int          strobes = 0;
  logic [1:0]  last_csb;
  logic        last_web;
  logic [3:0]  last_wmask;
  logic [8:0]  last_addr;
  logic [31:0] last_din;
  always @(negedge clk) begin
    if (rst_n && csb !== 2'b11) begin
      strobes++;
      last_csb   = csb;
      last_web   = web;
      last_wmask = wmask;
      last_addr  = maddr;
      last_din   = mdin;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic core_at_ack;

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    lat = 0;
    rdata = '0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        lat = i;
        rdata = dat_o;
        core_at_ack = core_rst_n;
        break;
      end
    end
    // Master keeps the strobe up one more edge; the FSM must not retrigger.
    @(posedge clk); #1;
    if (lat != 0) check("ack_single_cycle", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;
  int          s0;
  int          acks_seen;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_csb", {30'b0, csb}, 32'h3);
    check("rst_web", {31'b0, web}, 32'd1);
    check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("post_rst_csb", {30'b0, csb}, 32'h3);
    check("post_rst_word_count", {16'b0, word_count}, 32'd0);

    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat);
    check("status_init_lat", lat, 32'd1);
    check("status_init", rd, 32'h0);

    // Bank 0, word 4, full-word write
    s0 = strobes;
    wb_xfer(1'b1, 32'h3080_0010, 32'hDEAD_BEEF, 4'hF, rd, lat);
    check("wr0_lat", lat, 32'd2);
    check("wr0_strobes", strobes - s0, 32'd1);
    check("wr0_csb", {30'b0, last_csb}, 32'h2);
    check("wr0_web", {31'b0, last_web}, 32'd0);
    check("wr0_addr", {23'b0, last_addr}, 32'd4);
    check("wr0_wmask", {28'b0, last_wmask}, 32'hF);
    check("wr0_din", last_din, 32'hDEAD_BEEF);
    check("wr0_count", {16'b0, word_count}, 32'd1);

    s0 = strobes;
    wb_xfer(1'b0, 32'h3080_0010, 32'h0, 4'hF, rd, lat);
    check("rd0_lat", lat, RD_LAT);
    check("rd0_data", rd, RB ? 32'hDEAD_BEEF : 32'h0);
    check("rd0_strobes", strobes - s0, RB ? 32'd1 : 32'd0);

    // Bank 1, word 1, low half-word only
    wb_xfer(1'b1, 32'h3080_0804, 32'h1234_5678, 4'b0011, rd, lat);
    check("wr1_lat", lat, 32'd2);
    check("wr1_csb", {30'b0, last_csb}, 32'h1);
    check("wr1_wmask", {28'b0, last_wmask}, 32'h3);
    check("wr1_addr", {23'b0, last_addr}, 32'd1);
    check("wr1_count", {16'b0, word_count}, 32'd2);

    wb_xfer(1'b0, 32'h3080_0804, 32'h0, 4'hF, rd, lat);
    check("rd1_data", rd, RB ? 32'h0000_5678 : 32'h0);

    // Bank 2 is out of range with two banks
    s0 = strobes;
    wb_xfer(1'b1, 32'h3080_1000, 32'hCAFE_F00D, 4'hF, rd, lat);
    check("oob_wr_lat", lat, 32'd1);
    check("oob_wr_count", {16'b0, word_count}, 32'd2);
    wb_xfer(1'b0, 32'h3080_1000, 32'h0, 4'hF, rd, lat);
    check("oob_rd_lat", lat, 32'd1);
    check("oob_rd_data", rd, 32'h0);
    check("oob_strobes", strobes - s0, 32'd0);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat);
    check("status_oob", rd, 32'h0002_0001);

    // clr with hold kept set
    wb_xfer(1'b1, 32'h3000_0000, 32'h3, 4'h1, rd, lat);
    check("clr_lat", lat, 32'd1);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat);
    check("status_after_clr", rd, 32'h0);
    wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, lat);
    check("ctrl_rd_hold", rd, 32'h1);

    // Byte 0 disabled: hold must stay
    wb_xfer(1'b1, 32'h3000_0000, 32'h0, 4'hE, rd, lat);
    check("ctrl_sel_masked", {31'b0, core_rst_n}, 32'd0);

    wb_xfer(1'b1, 32'h3000_0000, 32'h0, 4'h1, rd, lat);
    check("release_at_ack", {31'b0, core_at_ack}, 32'd0);
    check("release_after_ack", {31'b0, core_rst_n}, 32'd1);
    wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, lat);
    check("ctrl_rd_released", rd, 32'h0);

    wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat);
    check("unmapped_rd", rd, 32'h0);
    wb_xfer(1'b0, 32'h3100_0004, 32'h0, 4'hF, rd, lat);
    check("wrong_base_no_ack", lat, 32'd0);

    // Reset asserted while the SRAM strobe is active (RD1, or WR without readback)
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = !RB; adr = 32'h3080_0010; dat_i = 32'h5555_AAAA; sel = 4'hF;
    @(posedge clk); #1;
    check("midtx_strobe", {30'b0, csb}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("midtx_csb", {30'b0, csb}, 32'h3);
    check("midtx_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("midtx_count", {16'b0, word_count}, 32'd0);
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) acks_seen++;
    end
    check("midtx_no_ack", acks_seen, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Saturation: preload the counter, then one more write
    @(negedge clk);
    force dut.u_regs.count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.u_regs.count_q;
    @(posedge clk); #1;
    check("sat_preload", {16'b0, word_count}, 32'h0000_FFFF);
    wb_xfer(1'b1, 32'h3080_0000, 32'h0BAD_0BAD, 4'hF, rd, lat);
    check("sat_hold", {16'b0, word_count}, 32'h0000_FFFF);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat);
    check("sat_status", rd, 32'hFFFF_0000);
    wb_xfer(1'b1, 32'h3000_0000, 32'h2, 4'h1, rd, lat);
    check("sat_clr", {16'b0, word_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
